// File: rtl/rr_starve_arbiter.sv
// Round-robin arbiter for one single-flit resource slot, with per-requester wait counters that promote starving requesters to absolute priority.
// Optional ARB_STATS_EN adds saturating grant / starvation-win counters.
module rr_starve_arbiter #(
  parameter int N            = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 4,
  localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          res_ready,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic [N-1:0]  starving
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_grants,
  output logic [15:0]   stat_starve_wins
`endif
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  starving_q, starving_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  logic [N-1:0]  elig;
  logic [N-1:0]  starve_set;
  logic          sel;
  logic          starve_win;
  logic          found;
  logic [IW-1:0] winner;
  int            j;

  always_comb begin
    // A requester holding grant is masked so it cannot win again while it drops req.
    elig       = req & ~grant_q;
    starve_set = elig & starving_q;
    sel        = res_ready && (|elig);
    starve_win = |starve_set;
    winner     = '0;
    found      = 1'b0;
    j          = 0;
    if (starve_win) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (starve_set[i]) winner = IW'(i);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr_q) + k;
        if (j >= N) j = j - N;
        if (!found && elig[j]) begin
          winner = IW'(j);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_d = '0;
    idx_d   = '0;
    ptr_d   = ptr_q;
    if (sel) begin
      grant_d = N'(1) << winner;
      idx_d   = winner;
      ptr_d   = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!req[i] || (sel && (winner == IW'(i)))) begin
        cnt_d[i] = '0;
      end else if (elig[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      starving_d[i] = (cnt_d[i] >= LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      starving_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      starving_q <= starving_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
  assign starving    = starving_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_grants_q, stat_grants_d;
  logic [15:0] stat_starve_q, stat_starve_d;

  // Counters track the grant being issued, so they line up with grant_valid.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_starve_d = stat_starve_q;
    if (sel && (stat_grants_q != 16'hFFFF)) stat_grants_d = stat_grants_q + 16'd1;
    if (sel && starve_win && (stat_starve_q != 16'hFFFF)) stat_starve_d = stat_starve_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_grants_q <= '0;
      stat_starve_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_starve_q <= stat_starve_d;
    end
  end

  assign stat_grants      = stat_grants_q;
  assign stat_starve_wins = stat_starve_q;
`endif

endmodule

// File: tb/tb_rr_starve_arbiter.sv
// Bench for rr_starve_arbiter: directed scenarios plus random traffic against an abstract arbitration model.
module tb_rr_starve_arbiter;
  localparam int N     = 4;
  localparam int LIMIT = 8;
  localparam int CMAX  = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         res_ready;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [N-1:0] starving;
`ifdef ARB_STATS_EN
  logic [15:0]  stat_grants;
  logic [15:0]  stat_starve_wins;
`endif

  rr_starve_arbiter #(.N(N), .STARVE_LIMIT(LIMIT), .CW(4)) dut (
    .clk(clk), .reset(reset), .req(req), .res_ready(res_ready),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .starving(starving)
`ifdef ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_starve_wins(stat_starve_wins)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: waiting time per requester, pointer, last winner (-1 = none).
  int m_wait [N];
  int m_ptr;
  int m_win;
  int m_grants;
  int m_swins;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  win;
    bit  starve_path;
    bit  elig [N];
    if (!reset) begin
      foreach (m_wait[i]) m_wait[i] = 0;
      m_ptr = 0; m_win = -1; m_grants = 0; m_swins = 0;
      return;
    end
    win = -1;
    starve_path = 0;
    for (int i = 0; i < N; i++) elig[i] = req[i] && (m_win != i);
    if (res_ready) begin
      for (int i = 0; i < N && win < 0; i++)
        if (elig[i] && m_wait[i] >= LIMIT) begin win = i; starve_path = 1; end
      for (int k = 0; k < N && win < 0; k++)
        if (elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (!req[i] || i == win) m_wait[i] = 0;
      else if (elig[i] && m_wait[i] < CMAX) m_wait[i]++;
    end
    if (win >= 0) begin
      m_ptr = (win + 1) % N;
      if (m_grants < 65535) m_grants++;
      if (starve_path && m_swins < 65535) m_swins++;
    end
    m_win = win;
  endtask

  task automatic compare();
    logic [N-1:0] eg, es;
    eg = '0; es = '0;
    if (m_win >= 0) eg[m_win] = 1'b1;
    for (int i = 0; i < N; i++) es[i] = (m_wait[i] >= LIMIT);
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_valid", 32'(grant_valid), 32'(m_win >= 0));
    chk("grant_idx", 32'(grant_idx), (m_win >= 0) ? m_win : 0);
    chk("starving", 32'(starving), 32'(es));
`ifdef ARB_STATS_EN
    chk("stat_grants", 32'(stat_grants), m_grants);
    chk("stat_starve_wins", 32'(stat_starve_wins), m_swins);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; res_ready = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seen;
    int           ngr;
    reset = 1'b0; req = 4'b1111; res_ready = 1'b1;
    foreach (m_wait[i]) m_wait[i] = 0;
    m_ptr = 0; m_win = -1; m_grants = 0; m_swins = 0;

    // Reset held with full request load.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_starving", 32'(starving), 0);
    end
    reset = 1'b1;
    step();
    chk("first_grant", 32'(grant), 32'h1);

    // Round robin: a granted requester drops req for its grant cycle.
    seen = '0; ngr = 0;
    for (int c = 0; c < 16; c++) begin
      req = 4'b1111 & ~grant;
      step();
      if (grant_valid && ngr < 8) begin
        seen[grant_idx] = 1'b1;
        ngr++;
        if (ngr == 4) chk("rr_cover4", 32'(seen), 32'hF);
      end
    end
    chk("rr_ngrants", ngr, 8);

    // Stall with res_ready low.
    do_reset();
    req = 4'b0110; res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_grant", 32'(grant), 0);
    end
    res_ready = 1'b1;
    step();
    chk("stall_idx1", 32'(grant_idx), 1);
    req = 4'b0100;
    step();
    chk("stall_idx2", 32'(grant_idx), 2);
    req = 4'b0000;
    step();

    // Starvation escalation.
    do_reset();
    req = 4'b1010; res_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 6) chk("starve_pre", 32'(starving), 0);
      if (c == 7) chk("starve_flag", 32'(starving), 32'b1010);
    end
    res_ready = 1'b1;
    step();
    chk("starve_idx1", 32'(grant_idx), 1);
    chk("starve_clr1", 32'(starving), 32'b1000);
    req = 4'b1000;
    step();
    chk("starve_idx3", 32'(grant_idx), 3);
    req = 4'b0000;
    step();

    // Request withdrawal restarts the wait count.
    do_reset();
    req = 4'b0100; res_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    req = 4'b0000;
    step();
    chk("wd_starving", 32'(starving), 0);
    req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 6) chk("wd_count7", 32'(starving[2]), 0);
      if (c == 7) chk("wd_count8", 32'(starving[2]), 1);
    end

    // Reset while a grant is showing clears it and the pointer.
    do_reset();
    req = 4'b0100; res_ready = 1'b1;
    step();
    chk("mid_grant", 32'(grant), 32'b0100);
    reset = 1'b0;
    step();
    chk("mid_rst_grant", 32'(grant), 0);
    reset = 1'b1; req = 4'b1010;
    step();
    chk("mid_ptr0", 32'(grant_idx), 1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 60) != 0);
      req       = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
